// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the dual-port GPU buffer RAM (memory_dp).
// MEMORY_PARITY_EN selects the per-lane parity build of memory_dp.
package gpu_mem_pkg;

    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_IDLE  = 1'b1
    } mem_state_t;

    function automatic int lanes(input int width, input int lane);
        return width / lane;
    endfunction

    // Lanes are at most 64 bits; callers zero-extend, which leaves even parity unchanged.
    function automatic logic parity(input logic [63:0] lane_bits);
        return ^lane_bits;
    endfunction

endpackage

// File: rtl/memory_clear_seq.sv
// Clear sequencer for memory_dp: sweeps every address once after reset or on request.
// Built the same way with or without MEMORY_PARITY_EN.
module memory_clear_seq
    import gpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    output logic          busy,
    output logic          clr_write,
    output logic [AW-1:0] clr_address,
    output mem_state_t    state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= MEM_CLEAR;
            busy        <= 1'b1;
            clr_address <= '0;
        end else begin
            case (state)
                MEM_CLEAR: begin
                    // busy falls together with the last write of the sweep.
                    if (clr_address == LAST_ADDR) begin
                        state       <= MEM_IDLE;
                        busy        <= 1'b0;
                        clr_address <= '0;
                    end else begin
                        clr_address <= clr_address + 1'b1;
                    end
                end
                MEM_IDLE: begin
                    if (clear) begin
                        state       <= MEM_CLEAR;
                        busy        <= 1'b1;
                        clr_address <= '0;
                    end
                end
                default: begin
                    state       <= MEM_CLEAR;
                    busy        <= 1'b1;
                    clr_address <= '0;
                end
            endcase
        end
    end

    assign clr_write = busy;

endmodule

// File: rtl/memory_dp.sv
// Dual-port GPU buffer RAM: masked write port, registered write-first read port, clear sweep.
// Define MEMORY_PARITY_EN to store one even-parity bit per lane and flag read mismatches.
module memory_dp
    import gpu_mem_pkg::*;
#(
    parameter int                 WIDTH       = 16,
    parameter int                 DEPTH       = 256,
    parameter int                 LANE        = 8,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0,
    localparam int                AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int                LANES       = lanes(WIDTH, LANE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    output logic             busy,
    input  logic             w_write,
    input  logic [AW-1:0]    w_address,
    input  logic [WIDTH-1:0] w_data,
    input  logic [LANES-1:0] w_mask,
    input  logic             r_read,
    input  logic [AW-1:0]    r_address,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    output logic             r_parity_err
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic             clr_write;
    logic [AW-1:0]    clr_address;
    mem_state_t       seq_state;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_en;
    logic             rd_accept;
    logic             collide;
    logic [WIDTH-1:0] rd_word;

    memory_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .busy        (busy),
        .clr_write   (clr_write),
        .clr_address (clr_address),
        .state       (seq_state)
    );

    assign wr_in_range = {1'b0, w_address} < DEPTH_W;
    assign rd_in_range = {1'b0, r_address} < DEPTH_W;

    // A clear request taken in IDLE beats a write presented in the same cycle.
    assign wr_en     = w_write && !busy && wr_in_range
                       && !(clear && (seq_state == MEM_IDLE));
    // Read handshake: r_read is sampled when busy is low; r_valid pulses for one
    // cycle on the next edge and r_data holds until the next accepted read.
    assign rd_accept = r_read && !busy;
    assign collide   = wr_en && (w_address == r_address);

    always_comb begin
        rd_word = mem[r_address];
        for (int i = 0; i < LANES; i++) begin
            if (collide && w_mask[i]) begin
                rd_word[i*LANE +: LANE] = w_data[i*LANE +: LANE];
            end
        end
        if (!rd_in_range) begin
            rd_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_write) begin
            mem[clr_address] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_mask[i]) begin
                    mem[w_address][i*LANE +: LANE] <= w_data[i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= rd_accept;
            if (rd_accept) begin
                r_data <= rd_word;
            end
        end
    end

`ifdef MEMORY_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] clr_par;
    logic [LANES-1:0] stored_par;
    logic             rd_err;

    always_comb begin
        clr_par    = '0;
        stored_par = par_mem[r_address];
        rd_err     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            clr_par[i] = parity(64'(CLEAR_VALUE[i*LANE +: LANE]));
            // Forwarded lanes come straight from w_data, so only stored lanes can mismatch.
            if (!(collide && w_mask[i])) begin
                rd_err = rd_err | (stored_par[i] ^ parity(64'(rd_word[i*LANE +: LANE])));
            end
        end
        if (!rd_in_range) begin
            rd_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_write) begin
            par_mem[clr_address] <= clr_par;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_mask[i]) begin
                    par_mem[w_address][i] <= parity(64'(w_data[i*LANE +: LANE]));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else if (rd_accept) begin
            r_parity_err <= rd_err;
        end
    end
`else
    assign r_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_dp.sv
// Self-checking bench for memory_dp: directed scenarios plus randomized traffic
// checked against an array model of the RAM.
module tb_memory_dp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        busy;
    logic        w_write;
    logic [7:0]  w_address;
    logic [15:0] w_data;
    logic [1:0]  w_mask;
    logic        r_read;
    logic [7:0]  r_address;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_parity_err;

    // Second instance with a non-power-of-two depth so out-of-range addresses exist.
    logic        o_busy;
    logic        o_w_write;
    logic [7:0]  o_w_address;
    logic [15:0] o_w_data;
    logic [1:0]  o_w_mask;
    logic        o_r_read;
    logic [7:0]  o_r_address;
    logic [15:0] o_r_data;
    logic        o_r_valid;
    logic        o_r_parity_err;
    logic        o_clear;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    memory_dp #(.WIDTH(16), .DEPTH(256), .LANE(8), .CLEAR_VALUE(16'h0000)) dut (
        .clk (clk), .reset_n (reset_n), .clear (clear), .busy (busy),
        .w_write (w_write), .w_address (w_address), .w_data (w_data), .w_mask (w_mask),
        .r_read (r_read), .r_address (r_address), .r_data (r_data), .r_valid (r_valid),
        .r_parity_err (r_parity_err)
    );

    memory_dp #(.WIDTH(16), .DEPTH(200), .LANE(8), .CLEAR_VALUE(16'h0000)) dut_oor (
        .clk (clk), .reset_n (reset_n), .clear (o_clear), .busy (o_busy),
        .w_write (o_w_write), .w_address (o_w_address), .w_data (o_w_data), .w_mask (o_w_mask),
        .r_read (o_r_read), .r_address (o_r_address), .r_data (o_r_data), .r_valid (o_r_valid),
        .r_parity_err (o_r_parity_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        clear = 0; w_write = 0; w_address = 0; w_data = 0; w_mask = 0;
        r_read = 0; r_address = 0;
        o_clear = 0; o_w_write = 0; o_w_address = 0; o_w_data = 0; o_w_mask = 0;
        o_r_read = 0; o_r_address = 0;
    endtask

    task automatic drive(input logic wr, input logic [7:0] wa, input logic [15:0] wd,
                         input logic [1:0] wm, input logic rd, input logic [7:0] ra);
        w_write = wr; w_address = wa; w_data = wd; w_mask = wm;
        r_read = rd; r_address = ra;
        tick();
        w_write = 0; r_read = 0;
    endtask

    task automatic drive_oor(input logic wr, input logic [7:0] wa, input logic [15:0] wd,
                             input logic rd, input logic [7:0] ra);
        o_w_write = wr; o_w_address = wa; o_w_data = wd; o_w_mask = 2'b11;
        o_r_read = rd; o_r_address = ra;
        tick();
        o_w_write = 0; o_r_read = 0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_merge(input logic [15:0] old, input logic [15:0] d,
                                                input logic [1:0] m);
        logic [15:0] r;
        r = old;
        if (m[0]) r[7:0]  = d[7:0];
        if (m[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic model_clear();
        foreach (model[i]) model[i] = 16'h0000;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        reset_n = 0;
        idle_inputs();
        tick(); tick();
        n_checks += 4;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
        if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
        if (r_data !== 16'h0) begin n_fail++; $display("FAIL reset_r_data: got %h want 0000", r_data); end
        if (r_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", r_parity_err); end
        reset_n = 1;
        count_busy(n);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL reset_busy_cycles: got %0d want 256", n); end
        model_clear();
        for (int a = 0; a < 256; a++) begin
            drive(0, 0, 0, 0, 1, 8'(a));
            n_checks++;
            if (r_valid !== 1'b1 || r_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL post_clear_read @%0d: got v=%b d=%h want v=1 d=0000", a, r_valid, r_data);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1, 8'd5, 16'hABCD, 2'b11, 0, 0);
        model[5] = model_merge(model[5], 16'hABCD, 2'b11);
        drive(0, 0, 0, 0, 1, 8'd5);
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== 16'hABCD) begin
            n_fail++; $display("FAIL write_read: got v=%b d=%h want v=1 d=abcd", r_valid, r_data);
        end
        tick();
        n_checks++;
        if (r_valid !== 1'b0 || r_data !== 16'hABCD) begin
            n_fail++; $display("FAIL valid_pulse_hold: got v=%b d=%h want v=0 d=abcd", r_valid, r_data);
        end
        drive(1, 8'd6, 16'h5555, 2'b00, 0, 0);
        drive(0, 0, 0, 0, 1, 8'd6);
        n_checks++;
        if (r_data !== 16'h0000) begin
            n_fail++; $display("FAIL mask_zero_noop: got %h want 0000", r_data);
        end
    endtask

    task automatic test_write_first();
        drive(1, 8'd5, 16'h1234, 2'b01, 1, 8'd5);
        model[5] = model_merge(model[5], 16'h1234, 2'b01);
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== 16'hAB34) begin
            n_fail++; $display("FAIL write_first: got v=%b d=%h want v=1 d=ab34", r_valid, r_data);
        end
        drive(0, 0, 0, 0, 1, 8'd5);
        n_checks++;
        if (r_data !== 16'hAB34) begin
            n_fail++; $display("FAIL write_first_stored: got %h want ab34", r_data);
        end
    endtask

    task automatic test_random();
        logic        wr, rd;
        logic [7:0]  wa, ra;
        logic [15:0] wd, e, last;
        logic [1:0]  wm;
        last = r_data;
        for (int k = 0; k < 400; k++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 15));
            wd = 16'($urandom);
            wm = 2'($urandom_range(0, 3));
            if (rd) begin
                e = (wr && wa == ra) ? model_merge(model[ra], wd, wm) : model[ra];
                exp_q.push_back(e);
            end
            if (wr) model[wa] = model_merge(model[wa], wd, wm);
            drive(wr, wa, wd, wm, rd, ra);
            n_checks++;
            if (rd) begin
                e = exp_q.pop_front();
                last = e;
                if (r_valid !== 1'b1 || r_data !== e || r_parity_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_read @%0d: got v=%b d=%h p=%b want v=1 d=%h p=0",
                             ra, r_valid, r_data, r_parity_err, e);
                end
            end else if (r_valid !== 1'b0 || r_data !== last) begin
                n_fail++;
                $display("FAIL random_idle: got v=%b d=%h want v=0 d=%h", r_valid, r_data, last);
            end
        end
    endtask

    task automatic test_out_of_range();
        int n = 0;
        while (o_busy && n < 1000) begin tick(); n++; end
        drive_oor(1, 8'd230, 16'hBEEF, 0, 0);
        drive_oor(0, 0, 0, 1, 8'd230);
        n_checks++;
        if (o_r_valid !== 1'b1 || o_r_data !== 16'h0000) begin
            n_fail++; $display("FAIL oor_read: got v=%b d=%h want v=1 d=0000", o_r_valid, o_r_data);
        end
        drive_oor(1, 8'd199, 16'h5A5A, 1, 8'd230);
        drive_oor(0, 0, 0, 1, 8'd199);
        n_checks++;
        if (o_r_valid !== 1'b1 || o_r_data !== 16'h5A5A) begin
            n_fail++; $display("FAIL oor_last_addr: got v=%b d=%h want v=1 d=5a5a", o_r_valid, o_r_data);
        end
        for (int a = 0; a < 199; a++) begin
            drive_oor(0, 0, 0, 1, 8'(a));
            n_checks++;
            if (o_r_data !== 16'h0000) begin
                n_fail++; $display("FAIL oor_no_alias @%0d: got %h want 0000", a, o_r_data);
            end
        end
    endtask

    task automatic test_clear_write();
        int n = 0;
        int rv = 0;
        drive(1, 8'd7, 16'h1111, 2'b11, 0, 0);
        drive(0, 0, 0, 0, 1, 8'd7);
        n_checks++;
        if (r_data !== 16'h1111) begin n_fail++; $display("FAIL pre_clear_data: got %h want 1111", r_data); end
        clear = 1; w_write = 1; w_address = 8'd7; w_data = 16'hFFFF; w_mask = 2'b11;
        tick();
        clear = 0;
        w_address = 8'd8; r_read = 1; r_address = 8'd7;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (r_valid) rv++;
        end
        w_write = 0; r_read = 0;
        model_clear();
        n_checks += 2;
        if (n !== 256) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want 256", n); end
        if (rv !== 0) begin n_fail++; $display("FAIL read_while_busy: got %0d valids want 0", rv); end
        drive(0, 0, 0, 0, 1, 8'd7);
        n_checks++;
        if (r_data !== 16'h0000) begin n_fail++; $display("FAIL clear_wins @7: got %h want 0000", r_data); end
        drive(0, 0, 0, 0, 1, 8'd8);
        n_checks++;
        if (r_data !== 16'h0000) begin n_fail++; $display("FAIL write_while_busy @8: got %h want 0000", r_data); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive(1, 8'd5, 16'h00C3, 2'b11, 0, 0);
        drive(0, 0, 0, 0, 1, 8'd5);
        clear = 1;
        tick();
        clear = 0;
        for (int k = 0; k < 100; k++) tick();
        reset_n = 0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || r_valid !== 1'b0 || r_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: got b=%b v=%b d=%h want b=1 v=0 d=0000", busy, r_valid, r_data);
        end
        tick();
        reset_n = 1;
        count_busy(n);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL restart_busy_cycles: got %0d want 256", n); end
        drive(0, 0, 0, 0, 1, 8'd5);
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== 16'h0000) begin
            n_fail++; $display("FAIL restart_read: got v=%b d=%h want v=1 d=0000", r_valid, r_data);
        end
    endtask

`ifdef MEMORY_PARITY_EN
    task automatic test_parity();
        drive(1, 8'd9, 16'h0F0F, 2'b11, 0, 0);
        drive(0, 0, 0, 0, 1, 8'd9);
        n_checks++;
        if (r_parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_clean: got %b want 0", r_parity_err); end
        dut.mem[9][0] = ~dut.mem[9][0];
        drive(0, 0, 0, 0, 1, 8'd9);
        n_checks++;
        if (r_parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_flip: got %b want 1", r_parity_err); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_random();
        test_out_of_range();
        test_clear_write();
        test_reset_mid_sweep();
`ifdef MEMORY_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
